// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA line fetch path.
// Colour words are packed {r[3:0],g[3:0],b[3:0]}.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [11:0] colour_t;

  typedef enum logic {
    IDLE,
    FETCH
  } fetch_state_t;

endpackage

// File: rtl/vga_line_fetcher_if.sv
// Framebuffer read port: req/ack request channel plus
// an in-order rvalid/rdata response channel.
interface vga_line_fetcher_if #(
  parameter int ADDR_W = 19
);
  import vga_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic              rvalid;
  colour_t           rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/line_buffer_2bank.sv
// Two-bank line store: one write port, one registered read port.
// Bank b occupies entries b*H_ACTIVE .. b*H_ACTIVE+H_ACTIVE-1.
module line_buffer_2bank
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int IDX_W    = $clog2(H_ACTIVE)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [IDX_W-1:0] widx,
  input  colour_t          wdata,
  input  logic             re,
  input  logic             rbank,
  input  logic [IDX_W-1:0] ridx,
  output colour_t          rdata
);

  localparam int AW = $clog2(2 * H_ACTIVE);
  localparam logic [AW-1:0] BANK_OFS = AW'(H_ACTIVE);

  colour_t ram [2*H_ACTIVE];

  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  assign waddr = (wbank ? BANK_OFS : '0) + AW'(widx);
  assign raddr = (rbank ? BANK_OFS : '0) + AW'(ridx);

  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
    if (re) begin
      rdata <= ram[raddr];
    end
  end

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches display lines into a two-bank buffer during blanking
// and serves pixels for the current row/column one cycle later.
module vga_line_fetcher
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         row,
  input  logic [10:0]         column,
  input  logic                en,
  output colour_t             colour_data,
  vga_line_fetcher_if.master  mem,
  output logic                underrun,
  input  logic                underrun_clr
);

  localparam int CNT_W = $clog2(H_ACTIVE + 1);
  localparam int IDX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [CNT_W-1:0]  CNT_END   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [10:0]       ROW_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [10:0]       ROW_VB    = 11'(V_ACTIVE);
  localparam logic [10:0]       COL_END   = 11'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              bank_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] next_base_q;
  logic [CNT_W-1:0]  req_cnt_q;
  logic [CNT_W-1:0]  rsp_cnt_q;
  logic [1:0]        line_valid_q;
  logic              underrun_q;
  logic              rd_en_q;
  colour_t           rd_data;

  logic t_h;
  logic t_v;
  logic trig;
  logic tgt_bank;
  logic start;
  logic done;
  logic req_on;
  logic rsp_fire;
  logic rd_en;
  logic set_und;

  assign t_h      = (row < ROW_LAST) && (column == COL_END);
  assign t_v      = (row == ROW_VB) && (column == '0);
  assign trig     = t_h | t_v;
  assign tgt_bank = t_v ? 1'b0 : ~row[0];

  assign req_on   = (state_q == FETCH) && (req_cnt_q < CNT_END);
  assign rsp_fire = (state_q == FETCH) && mem.rvalid
                  && (rsp_cnt_q < CNT_END);
  assign rd_en    = en && (row < ROW_VB) && (column < COL_END);

  assign set_und = (en && (column == '0) && !line_valid_q[row[0]])
                 || (trig && (state_q == FETCH));

  // req drops combinationally from the async-reset state register
  assign mem.req  = req_on;
  assign mem.addr = base_q + ADDR_W'(req_cnt_q);

  assign colour_data = rd_en_q ? rd_data : '0;
  assign underrun    = underrun_q;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          start   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rsp_fire && (rsp_cnt_q == CNT_LAST)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next_base tracks the scan itself, so a dropped trigger
  // does not shift the base of later lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_base_q <= LINE_STEP;
      base_q      <= '0;
      bank_q      <= 1'b0;
    end else begin
      if (t_v) begin
        next_base_q <= LINE_STEP;
      end else if (t_h) begin
        next_base_q <= next_base_q + LINE_STEP;
      end
      if (start) begin
        base_q <= t_v ? '0 : next_base_q;
        bank_q <= tgt_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cnt_q    <= '0;
      rsp_cnt_q    <= '0;
      line_valid_q <= '0;
    end else if (start) begin
      req_cnt_q              <= '0;
      rsp_cnt_q              <= '0;
      line_valid_q[tgt_bank] <= 1'b0;
    end else begin
      if (req_on && mem.ack) begin
        req_cnt_q <= req_cnt_q + 1'b1;
      end
      if (rsp_fire) begin
        rsp_cnt_q <= rsp_cnt_q + 1'b1;
      end
      if (done) begin
        line_valid_q[bank_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_q <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      rd_en_q <= rd_en;
      if (set_und) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  line_buffer_2bank #(
    .H_ACTIVE (H_ACTIVE),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (rsp_fire),
    .wbank (bank_q),
    .widx  (rsp_cnt_q[IDX_W-1:0]),
    .wdata (mem.rdata),
    .re    (rd_en),
    .rbank (row[0]),
    .ridx  (column[IDX_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: directed scenarios plus a randomised
// scan, checked against a line-level reference model.
module tb_vga_line_fetcher;
  import vga_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] row;
  logic [10:0] column;
  logic        en;
  logic        underrun_clr;
  colour_t     colour_data;
  logic        underrun;

  vga_line_fetcher_if #(.ADDR_W(AW)) mem ();

  vga_line_fetcher #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row          (row),
    .column       (column),
    .en           (en),
    .colour_data  (colour_data),
    .mem          (mem),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    int          due;
  } rsp_t;

  rsp_t    pend[$];
  colour_t m_buf [2][H];
  bit      m_wr  [2][H];
  bit      m_valid [2];
  bit      m_busy;
  int      m_line;
  int      m_issued;
  int      m_got;
  bit      m_und;
  colour_t exp_colour;
  bit      exp_known;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  bit ack_rand = 0;
  bit stall_all = 0;
  int stall_addr = -1;
  int stall_left = 0;
  int fires   = 0;
  int fires18 = 0;
  int f0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int r, input int c, input bit e,
                      input bit clr_i);
    logic        a;
    bit          rv;
    logic [11:0] rd;
    bit          rd_en;
    bit          th;
    bit          tv;
    bit          set;
    bit          was_busy;
    colour_t     nxt;
    bit          nxt_known;
    if (exp_known) chk("colour", colour_data, exp_colour);
    chk("req", mem.req, 32'(m_busy && m_issued < H));
    if (m_busy && m_issued < H)
      chk("addr", mem.addr, m_line * H + m_issued);
    chk("underrun", underrun, m_und);

    row          = 11'(r);
    column       = 11'(c);
    en           = e;
    underrun_clr = clr_i;

    if (stall_all) begin
      a = 1'b0;
    end else if (mem.req && int'(mem.addr) == stall_addr
                 && stall_left > 0) begin
      a = 1'b0;
      stall_left--;
    end else begin
      a = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    mem.ack = a;
    if (mem.req && a) begin
      pend.push_back('{data: mem.addr[11:0], due: cyc_n + 3});
      fires++;
      if (int'(mem.addr) == 18) fires18++;
    end
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      rv = 1'b1;
      rd = pend[0].data;
      void'(pend.pop_front());
    end else begin
      rv = 1'b0;
      rd = 12'($urandom);
    end
    mem.rvalid = rv;
    mem.rdata  = rd;

    rd_en     = e && r < V && c < H;
    nxt       = rd_en ? m_buf[r % 2][c] : 12'h000;
    nxt_known = !rd_en || m_wr[r % 2][c];
    th  = (r < V - 1) && (c == H);
    tv  = (r == V) && (c == 0);
    set = (e && c == 0 && !m_valid[r % 2]) || ((th || tv) && m_busy);
    was_busy = m_busy;
    if ((th || tv) && !m_busy) begin
      m_line   = tv ? 0 : r + 1;
      m_valid[m_line % 2] = 1'b0;
      m_issued = 0;
      m_got    = 0;
      m_busy   = 1'b1;
    end
    if (was_busy) begin
      if (m_issued < H && a) m_issued++;
      if (rv && m_got < H) begin
        m_buf[m_line % 2][m_got] = rd;
        m_wr[m_line % 2][m_got]  = 1'b1;
        m_got++;
        if (m_got == H) begin
          m_busy = 1'b0;
          m_valid[m_line % 2] = 1'b1;
        end
      end
    end
    if (set) m_und = 1'b1;
    else if (clr_i) m_und = 1'b0;
    exp_colour = nxt;
    exp_known  = nxt_known;
    cyc_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic park(input int n);
    repeat (n) step(5, 1, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 300) begin
      step(5, 1, 1'b0, 1'b0);
      k++;
    end
    chk("fetch_timeout", 32'(m_busy), 0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    mem.ack    = 1'b0;
    mem.rvalid = 1'b0;
    #1;
    chk("rst_req", mem.req, 0);
    chk("rst_addr", mem.addr, 0);
    chk("rst_colour", colour_data, 0);
    chk("rst_underrun", underrun, 0);
    pend.delete();
    m_busy     = 1'b0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_und      = 1'b0;
    exp_colour = '0;
    exp_known  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc_n++;
  endtask

  initial begin
    rst          = 1'b0;
    row          = 11'd5;
    column       = 11'd1;
    en           = 1'b0;
    underrun_clr = 1'b0;
    mem.ack      = 1'b0;
    mem.rvalid   = 1'b0;
    mem.rdata    = '0;
    m_busy       = 1'b0;
    m_und        = 1'b0;
    exp_colour   = '0;
    exp_known    = 1'b1;
    for (int b = 0; b < 2; b++) begin
      m_valid[b] = 1'b0;
      for (int i = 0; i < H; i++) begin
        m_buf[b][i] = '0;
        m_wr[b][i]  = 1'b0;
      end
    end

    @(negedge clk);
    do_reset();

    // reset in the middle of a line-0 fetch
    step(4, 0, 1'b0, 1'b0);
    park(6);
    do_reset();
    park(6);
    for (int c = 0; c < H; c++) step(0, c, 1'b1, 1'b0);
    step(5, 1, 1'b0, 1'b1);
    park(1);

    // vblank fetch of line 0
    step(4, 0, 1'b0, 1'b0);
    wait_idle();
    step(0, 3, 1'b1, 1'b0);
    chk("line0_px3", colour_data, 12'h003);

    // line 1, then line 2 with ack held off on address 18
    step(0, 8, 1'b0, 1'b0);
    wait_idle();
    stall_addr = 18;
    stall_left = 3;
    fires18    = 0;
    step(1, 8, 1'b0, 1'b0);
    wait_idle();
    chk("addr18_once", fires18, 1);
    step(2, 7, 1'b1, 1'b0);
    chk("line2_px7", colour_data, 12'h017);

    // line 3 stalled: underrun, sticky, clear, set-beats-clear
    stall_all = 1'b1;
    step(2, 8, 1'b0, 1'b0);
    park(2);
    step(3, 0, 1'b1, 1'b0);
    chk("und_set", underrun, 1);
    park(4);
    chk("und_sticky", underrun, 1);
    step(5, 1, 1'b0, 1'b1);
    chk("und_clr", underrun, 0);
    step(3, 0, 1'b1, 1'b1);
    chk("und_set_over_clr", underrun, 1);
    step(5, 1, 1'b0, 1'b1);
    chk("und_clr2", underrun, 0);
    stall_all = 1'b0;
    wait_idle();

    // gated reads and a trigger dropped during a fetch
    step(0, 3, 1'b0, 1'b0);
    chk("en0_zero", colour_data, 0);
    step(0, 9, 1'b1, 1'b0);
    chk("col9_zero", colour_data, 0);
    f0 = fires;
    step(4, 0, 1'b0, 1'b0);
    park(2);
    step(0, 8, 1'b0, 1'b0);
    chk("drop_und", underrun, 1);
    wait_idle();
    chk("drop_words", fires - f0, 8);
    step(5, 1, 1'b0, 1'b1);

    // randomised scan with random ack timing
    ack_rand = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int rr = 0; rr <= V; rr++) begin
        for (int c = 0; c < 25; c++) begin
          step((rr == 0) ? V : rr - 1, c,
               (c < H) && ($urandom_range(0, 3) != 0),
               $urandom_range(0, 11) == 0);
        end
      end
    end
    ack_rand = 1'b0;
    wait_idle();
    park(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
